// File: rtl/sort_pkg.sv
// Shared sizing, state encoding and helpers for the radix sorter blocks.
package sort_pkg;

  localparam int M    = 8;
  localparam int IDXW = (M > 1) ? $clog2(M) : 1;

  typedef logic [M-1:0] mask_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_PICK = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  function automatic int idx_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/h_slice.sv
// One narrowing step of the MSB-first scan: keep candidates with a 1 in this
// column, unless none have one, in which case the candidate set is unchanged.
module h_slice #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_mask,
  input  logic [N-1:0] i_col,
  output logic [N-1:0] o_mask
);

  logic [N-1:0] h;

  assign h      = i_mask & i_col;
  assign o_mask = (|h) ? h : i_mask;

endmodule

// File: rtl/radix_extract.sv
// Bit-serial extreme-key selector: loads a frame of M keys, then emits them
// one at a time in sorted order with their original indices.
//
//   state   | meaning
//   IDLE    | waiting for a frame, o_ready high
//   SCAN    | narrowing mask one key bit per cycle, MSB first
//   PICK    | latch lowest-index survivor as the winner
//   OUT     | winner presented on the output stream until accepted
module radix_extract
  import sort_pkg::*;
#(
  parameter int M       = sort_pkg::M,
  parameter int W       = 8,
  parameter bit DESCEND = 1'b1,
  localparam int IW     = idx_width(M),
  localparam int PW     = (W > 1) ? $clog2(W) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [M*W-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [W-1:0]  o_key,
  output logic [IW-1:0] o_idx,
  output logic          o_last
);

  state_e         state_q, state_d;
  logic [M*W-1:0] keys_q, keys_d;
  logic [M-1:0]   alive_q, alive_d;
  logic [M-1:0]   mask_q, mask_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   key_q, key_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           last_q, last_d;

  logic [M-1:0]   col;
  logic [M-1:0]   h_mask;
  logic [M-1:0]   win_oh;
  logic [IW-1:0]  pick_idx;
  logic [W-1:0]   pick_key;

  function automatic logic [IW-1:0] lowest_set(input logic [M-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (v[i]) r = IW'(i);
    end
    return r;
  endfunction

  function automatic int popcount(input logic [M-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < M; i++) n += int'(v[i]);
    return n;
  endfunction

  // Ascending order is a descending scan over inverted key bits.
  always_comb begin
    col = '0;
    for (int k = 0; k < M; k++) begin
      col[k] = keys_q[k*W + int'(ptr_q)] ^ ~DESCEND;
    end
  end

  h_slice #(.N(M)) u_h_slice (
    .i_mask (mask_q),
    .i_col  (col),
    .o_mask (h_mask)
  );

  always_comb begin
    win_oh = '0;
    for (int k = 0; k < M; k++) win_oh[k] = (int'(idx_q) == k);
  end

  assign pick_idx = lowest_set(mask_q);
  assign pick_key = keys_q[int'(pick_idx)*W +: W];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      keys_q  <= '0;
      alive_q <= '0;
      mask_q  <= '0;
      ptr_q   <= PW'(W - 1);
      valid_q <= 1'b0;
      key_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      keys_q  <= keys_d;
      alive_q <= alive_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_valid)        state_d = ST_SCAN;
      ST_SCAN: if (ptr_q == '0)    state_d = ST_PICK;
      ST_PICK:                     state_d = ST_OUT;
      ST_OUT:  if (i_ready)        state_d = last_q ? ST_IDLE : ST_SCAN;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    keys_d  = keys_q;
    alive_d = alive_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    key_d   = key_q;
    idx_d   = idx_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          keys_d  = i_data;
          alive_d = '1;
          mask_d  = '1;
          ptr_d   = PW'(W - 1);
        end
      end
      ST_SCAN: begin
        mask_d = h_mask;
        if (ptr_q != '0) ptr_d = ptr_q - 1'b1;
      end
      ST_PICK: begin
        key_d   = pick_key;
        idx_d   = pick_idx;
        last_d  = (popcount(alive_q) == 1);
        valid_d = 1'b1;
      end
      ST_OUT: begin
        if (i_ready) begin
          valid_d = 1'b0;
          alive_d = alive_q & ~win_oh;
          mask_d  = alive_q & ~win_oh;
          ptr_d   = PW'(W - 1);
        end
      end
      default: ;
    endcase
  end

  // o_ready is gated by reset so it drops immediately when reset asserts.
  always_comb begin
    o_ready = (state_q == ST_IDLE) && i_rst_n;
    o_valid = valid_q;
    o_key   = key_q;
    o_idx   = idx_q;
    o_last  = last_q;
  end

endmodule

// File: tb/tb_radix_extract.sv
// Directed bench for radix_extract (M=4, W=4): ordering, latency, stalls,
// ascending mode, mid-frame reset and loads ignored while busy.
module tb_radix_extract;

  localparam int M  = 4;
  localparam int W  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           va = 1'b0, vb = 1'b0;
  logic           i_ready = 1'b1;
  logic [M*W-1:0] i_data = '0;

  logic           a_ready, a_valid, a_last;
  logic [W-1:0]   a_key;
  logic [IW-1:0]  a_idx;
  logic           b_ready, b_valid, b_last;
  logic [W-1:0]   b_key;
  logic [IW-1:0]  b_idx;

  logic           use_b = 1'b0;
  logic           s_ready, s_valid, s_last;
  logic [W-1:0]   s_key;
  logic [IW-1:0]  s_idx;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int t0;

  radix_extract #(.M(M), .W(W), .DESCEND(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(va), .o_ready(a_ready),
    .i_data(i_data), .o_valid(a_valid), .i_ready(i_ready),
    .o_key(a_key), .o_idx(a_idx), .o_last(a_last)
  );

  radix_extract #(.M(M), .W(W), .DESCEND(1'b0)) dut_asc (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vb), .o_ready(b_ready),
    .i_data(i_data), .o_valid(b_valid), .i_ready(i_ready),
    .o_key(b_key), .o_idx(b_idx), .o_last(b_last)
  );

  assign s_ready = use_b ? b_ready : a_ready;
  assign s_valid = use_b ? b_valid : a_valid;
  assign s_key   = use_b ? b_key   : a_key;
  assign s_idx   = use_b ? b_idx   : a_idx;
  assign s_last  = use_b ? b_last  : a_last;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [M*W-1:0] pack(input int k0, input int k1, input int k2, input int k3);
    return {4'(k3), 4'(k2), 4'(k1), 4'(k0)};
  endfunction

  task automatic load(input string tag, input logic [M*W-1:0] d);
    chk({tag, ".ready"}, 32'(s_ready), 1);
    i_data = d;
    if (use_b) vb = 1'b1; else va = 1'b1;
    tick();
    va = 1'b0;
    vb = 1'b0;
    t0 = cyc;
  endtask

  // Waits for the next output, checks it, optionally stalls (and pokes a
  // load attempt during the stall), then completes the handshake.
  task automatic get_out(input string tag, input int k, input int idx, input int last,
                         input int stall, input bit poke, input logic [M*W-1:0] junk);
    int c;
    c = 0;
    i_ready = (stall == 0);
    while (!s_valid && c < 20) begin
      tick();
      c++;
    end
    chk({tag, ".lat"}, 32'(c), 5);
    chk({tag, ".key"}, 32'(s_key), 32'(k));
    chk({tag, ".idx"}, 32'(s_idx), 32'(idx));
    chk({tag, ".last"}, 32'(s_last), 32'(last));
    for (int s = 0; s < stall; s++) begin
      if (poke) begin
        i_data = junk;
        if (use_b) vb = 1'b1; else va = 1'b1;
      end
      tick();
      va = 1'b0;
      vb = 1'b0;
      chk({tag, ".hold_v"}, 32'(s_valid), 1);
      chk({tag, ".hold_k"}, 32'(s_key), 32'(k));
      chk({tag, ".hold_i"}, 32'(s_idx), 32'(idx));
      chk({tag, ".busy"}, 32'(s_ready), 0);
    end
    i_ready = 1'b1;
    tick();
    chk({tag, ".drop"}, 32'(s_valid), 0);
  endtask

  initial begin
    logic [M*W-1:0] none;
    none = '0;
    #2;
    chk("rst.valid", 32'(a_valid), 0);
    chk("rst.key", 32'(a_key), 0);
    chk("rst.idx", 32'(a_idx), 0);
    chk("rst.last", 32'(a_last), 0);
    chk("rst.ready", 32'(a_ready), 0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("rel.ready", 32'(a_ready), 1);

    // 1: descending, no stalls
    load("t1", pack(3, 9, 1, 9));
    get_out("t1o0", 9, 1, 0, 0, 1'b0, none);
    get_out("t1o1", 9, 3, 0, 0, 1'b0, none);
    get_out("t1o2", 3, 0, 0, 0, 1'b0, none);
    get_out("t1o3", 1, 2, 1, 0, 1'b0, none);
    chk("t1.frame", 32'(cyc - t0), 24);

    // 2: stall 3 cycles on the second output
    load("t2", pack(3, 9, 1, 9));
    get_out("t2o0", 9, 1, 0, 0, 1'b0, none);
    get_out("t2o1", 9, 3, 0, 3, 1'b0, none);
    get_out("t2o2", 3, 0, 0, 0, 1'b0, none);
    get_out("t2o3", 1, 2, 1, 0, 1'b0, none);
    chk("t2.frame", 32'(cyc - t0), 27);

    // 3: all-equal keys come out in index order
    load("t3", pack(0, 0, 0, 0));
    get_out("t3o0", 0, 0, 0, 0, 1'b0, none);
    get_out("t3o1", 0, 1, 0, 0, 1'b0, none);
    get_out("t3o2", 0, 2, 0, 0, 1'b0, none);
    get_out("t3o3", 0, 3, 1, 0, 1'b0, none);
    chk("t3.idle", 32'(a_ready), 1);

    // 4: ascending instance
    use_b = 1'b1;
    load("t4", pack(3, 9, 1, 9));
    get_out("t4o0", 1, 2, 0, 0, 1'b0, none);
    get_out("t4o1", 3, 0, 0, 0, 1'b0, none);
    get_out("t4o2", 9, 1, 0, 0, 1'b0, none);
    get_out("t4o3", 9, 3, 1, 0, 1'b0, none);
    use_b = 1'b0;

    // 5: reset during the second key's scan
    load("t5", pack(3, 9, 1, 9));
    get_out("t5o0", 9, 1, 0, 0, 1'b0, none);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5.rst_v", 32'(a_valid), 0);
    chk("t5.rst_k", 32'(a_key), 0);
    chk("t5.rst_r", 32'(a_ready), 0);
    #2 rst_n = 1'b1;
    tick();
    chk("t5.rel_r", 32'(a_ready), 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t5.quiet", 32'(a_valid), 0);
    end
    load("t5b", pack(15, 0, 7, 8));
    get_out("t5o0b", 15, 0, 0, 0, 1'b0, none);
    get_out("t5o1b", 8, 3, 0, 0, 1'b0, none);
    get_out("t5o2b", 7, 2, 0, 0, 1'b0, none);
    get_out("t5o3b", 0, 1, 1, 0, 1'b0, none);

    // 6: load attempts while busy are ignored
    load("t6", pack(3, 9, 1, 9));
    get_out("t6o0", 9, 1, 0, 2, 1'b1, pack(2, 5, 5, 12));
    get_out("t6o1", 9, 3, 0, 0, 1'b0, none);
    get_out("t6o2", 3, 0, 0, 1, 1'b1, pack(2, 5, 5, 12));
    get_out("t6o3", 1, 2, 1, 0, 1'b0, none);
    load("t6b", pack(2, 5, 5, 12));
    get_out("t6o0b", 12, 3, 0, 0, 1'b0, none);
    get_out("t6o1b", 5, 1, 0, 0, 1'b0, none);
    get_out("t6o2b", 5, 2, 0, 0, 1'b0, none);
    get_out("t6o3b", 2, 0, 1, 0, 1'b0, none);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
